uart_rx_os: RTL
===============

Name: uart_rx_os

Overview:
Stand-alone UART receiver with 16x oversampling, 3-sample majority vote, framing-error and overrun detection. Pairs with the existing UART transmitter as the far end of the serial link. Deserialises 8N1 frames from the asynchronous rx pin and presents each byte on a valid/ready handshake to the SoC bus bridge or an RX FIFO.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, ticks per bit period; must be even and >= 8
DIV (localparam), CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE) = 27, clocks per oversample tick; integer division truncates

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input; idle high
rx_data  out  8  received byte, LSB first on the line
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse when the stop bit samples 0
overrun  out  1  one-cycle pulse when a completed byte is dropped
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: rx_data=0x00, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, divider=0, tick count=0. Both synchroniser flops are set to 1. Reset takes effect on the same edge, including mid-frame. A partial byte is discarded.
- Input path: 2-FF synchroniser (2-cycle latency). A falling edge is detected on the synchronised signal, which is then registered (rx_s).
- Tick divider: counts 0..DIV-1 and pulses a tick at DIV-1. It is held at 0 in IDLE and starts counting on the cycle the start edge is detected. Bit time = DIV*OVERSAMPLE = 432 clk.
- Tick counter: 0..OVERSAMPLE-1, advanced per tick, wraps at the bit boundary. Votes are taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 (7, 8, 9). The bit value is the majority (>=2 of 3) and is resolved at tick 9.
- FSM:
  - IDLE: on a falling edge of rx_s -> START.
  - START: if the majority is 1 (glitch/false start) -> IDLE with no outputs. Otherwise, at tick wrap -> DATA with bit index=0.
  - DATA: at tick 9, shift the majority into shift[7] (right shift, LSB first). At wrap, if bit index==7 -> STOP, else bit index+1.
  - STOP: at tick 9:
    - Majority 1: deliver the byte, then -> IDLE immediately (mid-stop-bit). This allows back-to-back frames.
    - Majority 0: pulse frame_err, do not deliver, -> BRK.
  - BRK: wait until rx_s==1, then -> IDLE. This prevents a held-low line from retriggering.
- Delivery happens on the cycle after the tick-9 vote of the stop bit:
  - If rx_valid==0 or (rx_valid && rx_ready) that cycle: rx_data<=shift, rx_valid<=1.
  - Else: keep the old rx_data, rx_valid stays 1, and pulse overrun.
- Handshake: rx_valid clears on the edge after rx_valid && rx_ready, unless a delivery occurs in that same cycle. In that case the new byte loads and rx_valid stays 1.
- rx_data is stable while rx_valid=1. rx_ready with rx_valid=0 is ignored.
- frame_err and overrun are single-cycle pulses and are never asserted together.
- End-to-end latency: mid-stop-bit + 2 (sync) + 1 (delivery) cycles.
- Tolerance: sampling at the bit centre allows about ±4% total baud mismatch. A 434-clk/bit transmitter (CLOCK_FREQ/BAUD_RATE) is within spec.

Decomposition:
- Shared uart include/package: FSM state encodings (IDLE, START, DATA, STOP, BRK), a DIV computation function, and the vote tick constants. These are reused by the transmitter and the tick generator.
- One sub-module, uart_os_tick: a parameterised DIV counter with a synchronous clear. It outputs the tick pulse and tick count, and is shared with future oversampling blocks.

Test Plan:
- Frame 0x5A at 434 clk/bit, rx_ready=1 -> rx_valid rises once, rx_data=0x5A, frame_err=0, overrun=0, busy falls before the stop bit ends.
- rx low for 3 clk then high -> no rx_valid, no frame_err, busy returns to 0 within 1 bit time.
- 0x00 with the stop bit held low for 2 bit times -> one-cycle frame_err, no rx_valid. A following 0x3C frame after rx returns high yields rx_data=0x3C.
- 0x12 then 0x34 back-to-back with rx_ready=0 -> rx_data=0x12 held, rx_valid=1, one overrun pulse at the second stop bit. Then rx_ready=1 for one cycle -> rx_valid=0.
- rst pulsed during data bit 3 of 0xFF -> the next cycle has all outputs at reset values and busy=0. A subsequent 0xA5 frame yields rx_data=0xA5.
- 0xC3 sent at 415 and 449 clk/bit (±4% from 432) -> both received as 0xC3 with no frame_err.

Source files
------------

// File: rtl/uart_rx_os_pkg.sv
// Shared UART definitions: FSM state encodings, tick divider computation and
// the oversampling vote positions used by the receiver and tick generator.
package uart_rx_os_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BRK   = 3'd4;

    // Clocks per oversample tick; integer division truncates.
    function automatic int calc_div(input int clock_freq, input int baud_rate,
                                    input int oversample);
        return clock_freq / (baud_rate * oversample);
    endfunction

    // Three votes straddle the bit centre.
    function automatic int vote_tick_lo(input int oversample);
        return oversample / 2 - 1;
    endfunction

    function automatic int vote_tick_mid(input int oversample);
        return oversample / 2;
    endfunction

    function automatic int vote_tick_hi(input int oversample);
        return oversample / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// Oversampling tick generator: DIV-clock divider feeding a wrapping tick
// counter, both held at zero while clear is asserted.
module uart_os_tick #(
    parameter int DIV        = 27,
    parameter int OVERSAMPLE = 16,
    parameter int CW         = $clog2(OVERSAMPLE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic          tick,
    output logic [CW-1:0] tick_cnt
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_cnt;

    assign tick = !clear && (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
        end else if (div_cnt == DW'(DIV - 1)) begin
            div_cnt <= '0;
            if (tick_cnt == CW'(OVERSAMPLE - 1))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote;
// delivers bytes on a valid/ready handshake with framing/overrun pulses.
module uart_rx_os
    import uart_rx_os_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW  = $clog2(OVERSAMPLE);

    localparam logic [CW-1:0] T_LO   = CW'(vote_tick_lo(OVERSAMPLE));
    localparam logic [CW-1:0] T_MID  = CW'(vote_tick_mid(OVERSAMPLE));
    localparam logic [CW-1:0] T_HI   = CW'(vote_tick_hi(OVERSAMPLE));
    localparam logic [CW-1:0] T_LAST = CW'(OVERSAMPLE - 1);

    logic          rx_meta, rx_sync, rx_s;
    logic          fall;
    logic [2:0]    state;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          vote_lo, vote_mid;
    logic          deliver;
    logic          tick;
    logic [CW-1:0] tick_cnt;
    logic          tick_clear;
    logic          vote_now;
    logic          bit_wrap;
    logic          maj;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_s    <= rx_sync;
        end
    end

    assign fall       = rx_s && !rx_sync;
    assign tick_clear = (state == ST_IDLE) && !fall;
    assign vote_now   = tick && (tick_cnt == T_HI);
    assign bit_wrap   = tick && (tick_cnt == T_LAST);
    assign maj        = (vote_lo & vote_mid) | (vote_lo & rx_s) | (vote_mid & rx_s);
    assign busy       = (state != ST_IDLE);

    uart_os_tick #(
        .DIV       (DIV),
        .OVERSAMPLE(OVERSAMPLE),
        .CW        (CW)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (tick_clear),
        .tick    (tick),
        .tick_cnt(tick_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            vote_lo   <= 1'b1;
            vote_mid  <= 1'b1;
            deliver   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            deliver   <= 1'b0;
            frame_err <= 1'b0;
            if (tick && tick_cnt == T_LO)  vote_lo  <= rx_s;
            if (tick && tick_cnt == T_MID) vote_mid <= rx_s;
            case (state)
                ST_IDLE: begin
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (vote_now && maj) begin
                        state <= ST_IDLE;
                    end else if (bit_wrap) begin
                        state   <= ST_DATA;
                        bit_idx <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (vote_now) shift <= {maj, shift[7:1]};
                    if (bit_wrap) begin
                        if (bit_idx == 3'd7) state <= ST_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                ST_STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (vote_now) begin
                        if (maj) begin
                            deliver <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BRK;
                        end
                    end
                end
                ST_BRK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake: rx_data is transferred on any edge where rx_valid && rx_ready;
    // rx_valid then drops unless a new byte loads on that same edge, and
    // rx_data never changes while rx_valid is high and not accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
